// File: rtl/ycconfig_row.sv
// Morphle Logic configuration row: serial shadow chain, active register
// committed by apply, frame length checking and per-cell decode.
module ycconfig_row #(
    parameter int CELLS = 4
) (
    input  logic             confclk,
    input  logic             reset_n,
    input  logic             cbitin,
    input  logic             cshift,
    input  logic             cread,
    input  logic             capply,
    output logic             cbitout,
    output logic             cfull,
    output logic             cerr,
    output logic [CELLS-1:0] empty,
    output logic [CELLS-1:0] hblock,
    output logic [CELLS-1:0] hbypass,
    output logic [CELLS-1:0] hmatch0,
    output logic [CELLS-1:0] hmatch1,
    output logic [CELLS-1:0] vblock,
    output logic [CELLS-1:0] vbypass,
    output logic [CELLS-1:0] vmatch0,
    output logic [CELLS-1:0] vmatch1
);

    localparam int N  = 3 * CELLS;
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] FULL = CW'(N);
    localparam logic [CW-1:0] SAT  = CW'(N + 1);

    logic [N-1:0]  shadow;
    logic [N-1:0]  active;
    logic [CW-1:0] cnt;
    logic          din;

    // Readback recirculates the outgoing bit so the frame is preserved
    assign din     = cread ? shadow[N-1] : cbitin;
    assign cbitout = shadow[N-1];
    assign cfull   = (cnt == FULL);

    // Shadow chain: shifts toward the row's serial output
    always_ff @(posedge confclk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (cshift) begin
            shadow <= {shadow[N-2:0], din};
        end
    end

    // Active register and error flag capture the pre-edge shadow and count
    always_ff @(posedge confclk or negedge reset_n) begin
        if (!reset_n) begin
            active <= '0;
            cerr   <= 1'b0;
        end else if (capply) begin
            active <= shadow;
            cerr   <= (cnt != FULL);
        end
    end

    // Frame bit counter; a shift on the apply edge starts the next frame
    always_ff @(posedge confclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (capply) begin
            cnt <= cshift ? CW'(1) : '0;
        end else if (cshift && cnt != SAT) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Per-cell decode of the active configuration code
    always_comb begin
        empty   = '0;
        hblock  = '0;
        hbypass = '0;
        hmatch0 = '0;
        hmatch1 = '0;
        vblock  = '0;
        vbypass = '0;
        vmatch0 = '0;
        vmatch1 = '0;
        for (int i = 0; i < CELLS; i++) begin
            case (active[3*i +: 3])
                3'b000: empty[i] = 1'b1;
                3'b001: begin
                    hbypass[i] = 1'b1;
                    vbypass[i] = 1'b1;
                end
                3'b010: begin
                    hbypass[i] = 1'b1;
                    vblock[i]  = 1'b1;
                end
                3'b011: begin
                    hblock[i]  = 1'b1;
                    vbypass[i] = 1'b1;
                end
                3'b100: begin
                    hmatch1[i] = 1'b1;
                    vmatch1[i] = 1'b1;
                end
                3'b101: begin
                    hmatch0[i] = 1'b1;
                    vmatch0[i] = 1'b1;
                end
                3'b110: begin
                    hmatch0[i] = 1'b1;
                    hmatch1[i] = 1'b1;
                end
                default: begin
                    vmatch0[i] = 1'b1;
                    vmatch1[i] = 1'b1;
                end
            endcase
        end
    end

endmodule
